// File: rtl/bids22_round_ctrl.sv
// ----------------------------------------------------------------------------
// bids22_round_ctrl
//
// Host-side sequencer for the bids22 auction engine. Takes one round
// descriptor over a valid/ready handshake, walks the engine through its
// configuration commands (X/Y/Z balances, mask, lockout timer, bid cost),
// locks it, holds C_start for the programmed round length, waits for the
// roundOver strobe, unlocks, and offers the captured result over a second
// valid/ready handshake. This block is the sole master of the engine's
// command bus.
//
// Ports
//   clk, reset_n              clock (rising edge), async active-low reset
//   cfg_valid / cfg_ready     round descriptor handshake (ready only in IDLE)
//   cfg_xval/yval/zval        X/Y/Z balances
//   cfg_mask                  bidder enable mask
//   cfg_cost                  bid charge
//   cfg_round_len             cycles C_start is held (0 treated as 1)
//   C_op, C_data, C_start     registered engine command bus
//   ready, err                engine handshake and error code
//   roundOver, maxBid,        engine result strobe and result fields
//   X_win, Y_win, Z_win
//   res_valid / res_ready     result handshake
//   res_maxbid, res_winner,   captured result (winner 0 none, 1 X, 2 Y, 3 Z;
//   res_err                   err 3'b111 means roundOver timeout)
//   busy                      high whenever a round is in progress
// ----------------------------------------------------------------------------
module bids22_round_ctrl #(
   parameter logic [31:0] KEY           = 32'h0F0F0F0F,
   parameter logic [31:0] LOCKOUT_TIMER = 32'h0000000F,
   parameter int unsigned ROVER_TIMEOUT = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic [31:0] cfg_xval,
   input  logic [31:0] cfg_yval,
   input  logic [31:0] cfg_zval,
   input  logic [2:0]  cfg_mask,
   input  logic [31:0] cfg_cost,
   input  logic [15:0] cfg_round_len,
   output logic [3:0]  C_op,
   output logic [31:0] C_data,
   output logic        C_start,
   input  logic        ready,
   input  logic [2:0]  err,
   input  logic        roundOver,
   input  logic [31:0] maxBid,
   input  logic        X_win,
   input  logic        Y_win,
   input  logic        Z_win,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_maxbid,
   output logic [1:0]  res_winner,
   output logic [2:0]  res_err,
   output logic        busy
);

   // Engine opcodes
   localparam logic [3:0] OP_NOOP   = 4'd0;
   localparam logic [3:0] OP_UNLOCK = 4'd1;
   localparam logic [3:0] OP_LOCK   = 4'd2;
   localparam logic [3:0] OP_LOADX  = 4'd3;
   localparam logic [3:0] OP_LOADY  = 4'd4;
   localparam logic [3:0] OP_LOADZ  = 4'd5;
   localparam logic [3:0] OP_MASK   = 4'd6;
   localparam logic [3:0] OP_TIMER  = 4'd7;
   localparam logic [3:0] OP_COST   = 4'd8;

   // Sequencer states
   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_LDX    = 4'd1;
   localparam logic [3:0] S_LDY    = 4'd2;
   localparam logic [3:0] S_LDZ    = 4'd3;
   localparam logic [3:0] S_MSK    = 4'd4;
   localparam logic [3:0] S_TMR    = 4'd5;
   localparam logic [3:0] S_CST    = 4'd6;
   localparam logic [3:0] S_LCK    = 4'd7;
   localparam logic [3:0] S_RUN    = 4'd8;
   localparam logic [3:0] S_CLOSE  = 4'd9;
   localparam logic [3:0] S_UNLK   = 4'd10;
   localparam logic [3:0] S_RESULT = 4'd11;

   // Last CLOSE cycle index on which roundOver is still accepted
   localparam logic [7:0] TO_LAST = 8'(ROVER_TIMEOUT - 1);

   logic [3:0]  state;
   logic [3:0]  nxt_state;

   logic [31:0] x_q;
   logic [31:0] y_q;
   logic [31:0] z_q;
   logic [2:0]  mask_q;
   logic [31:0] cost_q;
   logic [15:0] len_q;

   logic [15:0] run_cnt;
   logic [7:0]  to_cnt;

   logic        cfg_stage;
   logic        cfg_fail;
   logic        rover_timeout;
   logic [31:0] x_nxt;

   logic [3:0]  op_d;
   logic [31:0] data_d;
   logic        start_d;

   // Priority X > Y > Z; no flag set means no winner.
   function automatic logic [1:0] pick_winner(input logic xw, input logic yw, input logic zw);
      if (xw)      return 2'd1;
      else if (yw) return 2'd2;
      else if (zw) return 2'd3;
      else         return 2'd0;
   endfunction

   assign cfg_stage = (state == S_LDX) || (state == S_LDY) || (state == S_LDZ) ||
                      (state == S_MSK) || (state == S_TMR) || (state == S_CST);
   assign cfg_fail      = cfg_stage && ready && (err != 3'b000);
   assign rover_timeout = (state == S_CLOSE) && !roundOver && (to_cnt == TO_LAST);

   // LDX is only entered straight from IDLE, on the same edge that latches the
   // descriptor, so its bus value must come from the live input that cycle.
   assign x_nxt = (state == S_IDLE) ? cfg_xval : x_q;

   assign cfg_ready = reset_n && (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign res_valid = (state == S_RESULT);

   always_comb begin
      nxt_state = state;
      case (state)
         S_IDLE:   if (cfg_valid) nxt_state = S_LDX;
         S_LDX:    if (ready) nxt_state = S_LDY;
         S_LDY:    if (ready) nxt_state = S_LDZ;
         S_LDZ:    if (ready) nxt_state = S_MSK;
         S_MSK:    if (ready) nxt_state = S_TMR;
         S_TMR:    if (ready) nxt_state = S_CST;
         S_CST:    if (ready) nxt_state = S_LCK;
         S_LCK:    if (ready) nxt_state = S_RUN;
         S_RUN:    if (run_cnt <= 16'd1) nxt_state = S_CLOSE;
         S_CLOSE:  if (roundOver || (to_cnt == TO_LAST)) nxt_state = S_UNLK;
         S_UNLK:   nxt_state = S_RESULT;
         S_RESULT: if (res_ready) nxt_state = S_IDLE;
         default:  nxt_state = S_IDLE;
      endcase
      // A config error skips Lock entirely, leaving the engine unlocked.
      if (cfg_fail) nxt_state = S_RESULT;
   end

   // The bus registers are loaded from the state being entered, so what the
   // engine sees on any cycle is a pure function of the current state.
   always_comb begin
      op_d    = OP_NOOP;
      data_d  = '0;
      start_d = 1'b0;
      case (nxt_state)
         S_LDX:   begin op_d = OP_LOADX;  data_d = x_nxt;              end
         S_LDY:   begin op_d = OP_LOADY;  data_d = y_q;                end
         S_LDZ:   begin op_d = OP_LOADZ;  data_d = z_q;                end
         S_MSK:   begin op_d = OP_MASK;   data_d = {29'b0, mask_q};    end
         S_TMR:   begin op_d = OP_TIMER;  data_d = LOCKOUT_TIMER;      end
         S_CST:   begin op_d = OP_COST;   data_d = cost_q;             end
         S_LCK:   begin op_d = OP_LOCK;   data_d = KEY;                end
         S_RUN:   start_d = 1'b1;
         S_UNLK:  begin op_d = OP_UNLOCK; data_d = KEY;                end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         C_op       <= OP_NOOP;
         C_data     <= '0;
         C_start    <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
         z_q        <= '0;
         mask_q     <= '0;
         cost_q     <= '0;
         len_q      <= '0;
         run_cnt    <= '0;
         to_cnt     <= '0;
         res_maxbid <= '0;
         res_winner <= '0;
         res_err    <= '0;
      end else begin
         state   <= nxt_state;
         C_op    <= op_d;
         C_data  <= data_d;
         C_start <= start_d;

         if ((state == S_IDLE) && cfg_valid) begin
            x_q    <= cfg_xval;
            y_q    <= cfg_yval;
            z_q    <= cfg_zval;
            mask_q <= cfg_mask;
            cost_q <= cfg_cost;
            len_q  <= cfg_round_len;
         end

         // Reloaded on every LCK cycle; the value from the advancing cycle is
         // the one RUN starts with. A zero length still runs one cycle.
         if (state == S_LCK)
            run_cnt <= (len_q == 16'd0) ? 16'd1 : len_q;
         else if (state == S_RUN)
            run_cnt <= run_cnt - 16'd1;

         if (state == S_CLOSE)
            to_cnt <= to_cnt + 8'd1;
         else
            to_cnt <= '0;

         if (cfg_fail) begin
            res_err    <= err;
            res_winner <= 2'd0;
            res_maxbid <= '0;
         end else if ((state == S_CLOSE) && roundOver) begin
            res_maxbid <= maxBid;
            res_err    <= err;
            res_winner <= pick_winner(X_win, Y_win, Z_win);
         end else if (rover_timeout) begin
            res_err    <= 3'b111;
            res_winner <= 2'd0;
            res_maxbid <= '0;
         end
      end
   end

endmodule

// File: tb/tb_bids22_round_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bids22_round_ctrl
//
// Directed bench for bids22_round_ctrl. A reactive engine stand-in answers
// the command bus (ready stalls, config errors, roundOver timing, result
// fields) and a result consumer applies res_ready backpressure. For each
// round a phase-level model expands the descriptor and engine behaviour into
// the expected per-cycle bus/handshake trace plus expected result, which the
// main process compares every cycle. Literal checks after each round pin the
// model against hand-computed values.
// ----------------------------------------------------------------------------
module tb_bids22_round_ctrl;

   localparam logic [31:0] KEY = 32'h0F0F0F0F;
   localparam logic [31:0] TMR = 32'h0000000F;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [31:0] cfg_xval, cfg_yval, cfg_zval, cfg_cost;
   logic [2:0]  cfg_mask;
   logic [15:0] cfg_round_len;
   logic [3:0]  C_op;
   logic [31:0] C_data;
   logic        C_start;
   logic        ready;
   logic [2:0]  err;
   logic        roundOver;
   logic [31:0] maxBid;
   logic        X_win, Y_win, Z_win;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_maxbid;
   logic [1:0]  res_winner;
   logic [2:0]  res_err;
   logic        busy;

   always #5 clk = ~clk;

   bids22_round_ctrl dut (
      .clk(clk), .reset_n(reset_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_xval(cfg_xval), .cfg_yval(cfg_yval), .cfg_zval(cfg_zval),
      .cfg_mask(cfg_mask), .cfg_cost(cfg_cost), .cfg_round_len(cfg_round_len),
      .C_op(C_op), .C_data(C_data), .C_start(C_start),
      .ready(ready), .err(err), .roundOver(roundOver), .maxBid(maxBid),
      .X_win(X_win), .Y_win(Y_win), .Z_win(Z_win),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_maxbid(res_maxbid), .res_winner(res_winner), .res_err(res_err),
      .busy(busy)
   );

   // Scenario description (descriptor + engine/consumer behaviour)
   logic [31:0] sc_x, sc_y, sc_z, sc_cost, sc_maxbid;
   logic [2:0]  sc_mask, sc_err_val, sc_rerr;
   logic [15:0] sc_len;
   logic [3:0]  sc_stall_op = 4'hF;  // 4'hF: no stall
   logic [3:0]  sc_err_op   = 4'hF;  // 4'hF: no config error
   int          sc_stall    = 0;
   int          sc_delay    = 0;     // CLOSE cycle index of roundOver, <0 never
   int          sc_hold     = 0;     // cycles res_ready held low
   logic        sc_xw, sc_yw, sc_zw;
   logic        sc_poke;             // pulse cfg_valid during RUN

   typedef struct {
      logic [3:0]  op;
      logic [31:0] data;
      logic        start;
      logic        bsy;
      logic        crdy;
      logic        rv;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] e_max;
   logic [1:0]  e_win;
   logic [2:0]  e_err;

   int n_cmp = 0;
   int n_bad = 0;

   // Per-round observations
   int          start_cyc, unlk_cyc, lock_cyc, op4_cyc;
   logic [31:0] op_sig;
   logic [3:0]  prev_op;
   logic [31:0] last_max;
   logic [1:0]  last_win;
   logic [2:0]  last_err;
   int          w;

   // Engine / consumer stand-in state
   int stall_left, hold_left, close_idx;
   bit armed;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", nm, act, expv);
      end
   endtask

   task automatic push(input logic [3:0] op, input logic [31:0] data, input logic start,
                       input logic bsy, input logic crdy, input logic rv);
      exp_t e;
      e.op = op; e.data = data; e.start = start; e.bsy = bsy; e.crdy = crdy; e.rv = rv;
      exp_q.push_back(e);
   endtask

   task automatic set_sc(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                         input logic [2:0] m, input logic [31:0] c, input logic [15:0] len,
                         input logic [3:0] stall_op, input int stall,
                         input logic [3:0] err_op, input logic [2:0] err_val,
                         input int delay, input logic [2:0] rerr, input logic [31:0] mb,
                         input logic xw, input logic yw, input logic zw,
                         input int hold, input logic poke);
      sc_x = x; sc_y = y; sc_z = z; sc_mask = m; sc_cost = c; sc_len = len;
      sc_stall_op = stall_op; sc_stall = stall; sc_err_op = err_op; sc_err_val = err_val;
      sc_delay = delay; sc_rerr = rerr; sc_maxbid = mb;
      sc_xw = xw; sc_yw = yw; sc_zw = zw; sc_hold = hold; sc_poke = poke;
   endtask

   // Expand the scenario into the expected cycle trace, phase by phase.
   task automatic build_expected();
      logic [31:0] cdata [6];
      logic [3:0]  op;
      int          n;
      bit          failed;
      exp_q.delete();
      cdata[0] = sc_x; cdata[1] = sc_y; cdata[2] = sc_z;
      cdata[3] = {29'b0, sc_mask}; cdata[4] = TMR; cdata[5] = sc_cost;
      failed = 0;
      for (int k = 0; k < 6; k++) begin
         op = 4'(3 + k);
         n  = 1 + ((op == sc_stall_op) ? sc_stall : 0);
         for (int j = 0; j < n; j++) push(op, cdata[k], 1'b0, 1'b1, 1'b0, 1'b0);
         if (op == sc_err_op) begin
            failed = 1;
            break;
         end
      end
      if (failed) begin
         e_err = sc_err_val; e_win = 2'd0; e_max = 32'd0;
      end else begin
         n = 1 + ((sc_stall_op == 4'd2) ? sc_stall : 0);
         for (int j = 0; j < n; j++) push(4'd2, KEY, 1'b0, 1'b1, 1'b0, 1'b0);
         n = (sc_len == 16'd0) ? 1 : int'(sc_len);
         for (int j = 0; j < n; j++) push(4'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
         if (sc_delay >= 0 && sc_delay < 8) begin
            n = sc_delay + 1;
            e_err = sc_rerr; e_max = sc_maxbid;
            e_win = sc_xw ? 2'd1 : sc_yw ? 2'd2 : sc_zw ? 2'd3 : 2'd0;
         end else begin
            n = 8;
            e_err = 3'b111; e_max = 32'd0; e_win = 2'd0;
         end
         for (int j = 0; j < n; j++) push(4'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
         push(4'd1, KEY, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      for (int j = 0; j <= sc_hold; j++) push(4'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      push(4'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic run_round(input string tag);
      int wt;
      @(negedge clk);
      wt = 0;
      while (!cfg_ready && wt < 20) begin
         @(negedge clk);
         wt++;
      end
      chk($sformatf("%s cfg_ready idle", tag), 32'(cfg_ready), 32'd1);
      build_expected();
      start_cyc = 0; unlk_cyc = 0; lock_cyc = 0; op4_cyc = 0;
      op_sig = 32'd0; prev_op = 4'd0;
      cfg_xval = sc_x; cfg_yval = sc_y; cfg_zval = sc_z;
      cfg_mask = sc_mask; cfg_cost = sc_cost; cfg_round_len = sc_len;
      cfg_valid = 1'b1;
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         cfg_valid = sc_poke && exp_q[i].start;
         if (cfg_valid) begin
            cfg_xval = 32'hDEADBEEF; cfg_round_len = 16'd50;
         end
         chk($sformatf("%s c%0d C_op", tag, i), 32'(C_op), 32'(exp_q[i].op));
         chk($sformatf("%s c%0d C_data", tag, i), C_data, exp_q[i].data);
         chk($sformatf("%s c%0d C_start", tag, i), 32'(C_start), 32'(exp_q[i].start));
         chk($sformatf("%s c%0d busy", tag, i), 32'(busy), 32'(exp_q[i].bsy));
         chk($sformatf("%s c%0d cfg_ready", tag, i), 32'(cfg_ready), 32'(exp_q[i].crdy));
         chk($sformatf("%s c%0d res_valid", tag, i), 32'(res_valid), 32'(exp_q[i].rv));
         if (exp_q[i].rv) begin
            chk($sformatf("%s c%0d res_maxbid", tag, i), res_maxbid, e_max);
            chk($sformatf("%s c%0d res_winner", tag, i), 32'(res_winner), 32'(e_win));
            chk($sformatf("%s c%0d res_err", tag, i), 32'(res_err), 32'(e_err));
            last_max = res_maxbid; last_win = res_winner; last_err = res_err;
         end
         if (C_start) start_cyc++;
         if (C_op == 4'd1) unlk_cyc++;
         if (C_op == 4'd2) lock_cyc++;
         if (C_op == 4'd4) op4_cyc++;
         if (C_op != prev_op && C_op != 4'd0) op_sig = {op_sig[27:0], C_op};
         prev_op = C_op;
      end
      cfg_valid = 1'b0;
   endtask

   // Engine and result-consumer stand-in, reacting to the bus each cycle.
   initial begin
      ready = 1'b1; err = 3'b0; roundOver = 1'b0; maxBid = 32'd0;
      X_win = 1'b0; Y_win = 1'b0; Z_win = 1'b0; res_ready = 1'b0;
      stall_left = 0; hold_left = 0; close_idx = -1; armed = 0;
      forever begin
         @(negedge clk);
         if (!busy) begin
            stall_left = sc_stall; armed = 0; close_idx = -1;
         end
         if (C_op == sc_stall_op && stall_left > 0) begin
            ready = 1'b0;
            stall_left--;
         end else begin
            ready = 1'b1;
         end
         if (C_start) armed = 1;
         roundOver = 1'b0;
         if (armed && !C_start && C_op == 4'd0) begin
            close_idx++;
            if (close_idx == sc_delay) roundOver = 1'b1;
         end
         if (C_op != 4'd0) armed = 0;
         err = roundOver ? sc_rerr : ((C_op == sc_err_op && ready) ? sc_err_val : 3'b0);
         maxBid = sc_maxbid; X_win = sc_xw; Y_win = sc_yw; Z_win = sc_zw;
         if (res_valid) begin
            if (hold_left > 0) begin
               res_ready = 1'b0;
               hold_left--;
            end else begin
               res_ready = 1'b1;
            end
         end else begin
            res_ready = 1'b0;
            hold_left = sc_hold;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0; cfg_valid = 1'b0;
      cfg_xval = 0; cfg_yval = 0; cfg_zval = 0; cfg_mask = 0; cfg_cost = 0; cfg_round_len = 0;
      set_sc(0, 0, 0, 0, 0, 0, 4'hF, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      chk("rst C_op", 32'(C_op), 32'd0);
      chk("rst C_data", C_data, 32'd0);
      chk("rst C_start", 32'(C_start), 32'd0);
      chk("rst res_valid", 32'(res_valid), 32'd0);
      chk("rst res_maxbid", res_maxbid, 32'd0);
      chk("rst res_winner", 32'(res_winner), 32'd0);
      chk("rst res_err", 32'(res_err), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst cfg_ready", 32'(cfg_ready), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("post-rst cfg_ready", 32'(cfg_ready), 32'd1);

      // Nominal round, Z wins with 300
      set_sc(100, 200, 300, 3'd7, 1, 4, 4'hF, 0, 4'hF, 0, 1, 3'd0, 300, 0, 0, 1, 0, 0);
      run_round("nom");
      chk("nom op sequence", op_sig, 32'h34567821);
      chk("nom start cycles", 32'(start_cyc), 32'd4);
      chk("nom unlock cycles", 32'(unlk_cyc), 32'd1);
      chk("nom maxbid", last_max, 32'd300);
      chk("nom winner", 32'(last_win), 32'd3);
      chk("nom err", 32'(last_err), 32'd0);

      // Backpressure on LoadY and on the result; X and Y both flag, X wins
      set_sc(32'h11111111, 32'h22222222, 32'h33333333, 3'd5, 32'h44, 2,
             4'd4, 3, 4'hF, 0, 0, 3'd0, 32'h55, 1, 1, 0, 5, 0);
      run_round("bp");
      chk("bp LoadY cycles", 32'(op4_cyc), 32'd4);
      chk("bp winner", 32'(last_win), 32'd1);
      chk("bp maxbid", last_max, 32'h55);

      // Config error on SetXYZmask
      set_sc(7, 8, 9, 3'd3, 2, 4, 4'hF, 0, 4'd6, 3'b100, 0, 3'd0, 99, 1, 0, 0, 1, 0);
      run_round("cfgerr");
      chk("cfgerr lock cycles", 32'(lock_cyc), 32'd0);
      chk("cfgerr start cycles", 32'(start_cyc), 32'd0);
      chk("cfgerr op sequence", op_sig, 32'h00003456);
      chk("cfgerr res_err", 32'(last_err), 32'd4);

      // Engine reports err with roundOver and no winner
      set_sc(1, 2, 3, 3'd1, 1, 3, 4'hF, 0, 4'hF, 0, 3, 3'b101, 77, 0, 0, 0, 0, 0);
      run_round("rerr");
      chk("rerr res_err", 32'(last_err), 32'd5);
      chk("rerr winner", 32'(last_win), 32'd0);
      chk("rerr maxbid", last_max, 32'd77);

      // roundOver never arrives
      set_sc(5, 6, 7, 3'd7, 1, 2, 4'hF, 0, 4'hF, 0, -1, 3'd0, 123, 1, 0, 0, 0, 0);
      run_round("tmo");
      chk("tmo res_err", 32'(last_err), 32'd7);
      chk("tmo unlock cycles", 32'(unlk_cyc), 32'd1);
      chk("tmo maxbid", last_max, 32'd0);

      // Zero round length, cfg_valid poked during RUN, roundOver on last allowed cycle
      set_sc(9, 9, 9, 3'd2, 3, 0, 4'hF, 0, 4'hF, 0, 7, 3'd0, 42, 0, 1, 1, 0, 1);
      run_round("len0");
      chk("len0 start cycles", 32'(start_cyc), 32'd1);
      chk("len0 winner", 32'(last_win), 32'd2);
      chk("len0 maxbid", last_max, 32'd42);

      // Reset asserted mid-RUN
      set_sc(1, 1, 1, 3'd7, 1, 20, 4'hF, 0, 4'hF, 0, -1, 3'd0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      cfg_xval = 1; cfg_yval = 1; cfg_zval = 1; cfg_mask = 3'd7; cfg_cost = 1; cfg_round_len = 20;
      cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      w = 0;
      while (!C_start && w < 30) begin
         @(negedge clk);
         w++;
      end
      chk("mid reached run", 32'(C_start), 32'd1);
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("mid rst C_start", 32'(C_start), 32'd0);
      chk("mid rst C_op", 32'(C_op), 32'd0);
      chk("mid rst C_data", C_data, 32'd0);
      chk("mid rst busy", 32'(busy), 32'd0);
      chk("mid rst cfg_ready", 32'(cfg_ready), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("mid release cfg_ready", 32'(cfg_ready), 32'd1);
      @(negedge clk);
      chk("mid idle busy", 32'(busy), 32'd0);
      chk("mid idle C_op", 32'(C_op), 32'd0);
      chk("mid idle C_start", 32'(C_start), 32'd0);

      // Recovery round after reset
      set_sc(400, 500, 600, 3'd6, 9, 3, 4'hF, 0, 4'hF, 0, 2, 3'd0, 600, 0, 0, 1, 2, 0);
      run_round("rec");
      chk("rec start cycles", 32'(start_cyc), 32'd3);
      chk("rec winner", 32'(last_win), 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bids22_round_ctrl.md
Name: bids22_round_ctrl

Overview:
- Host-side sequencer for the bids22 auction engine.
- Accepts one round descriptor over a valid/ready handshake, then drives the engine's C_op/C_data/C_start command bus to:
  - load X/Y/Z balances, mask, lockout timer and bid cost;
  - lock the engine, run the round for a programmed number of cycles, close it, capture the result, and unlock.
- Presents the round result over a second valid/ready handshake. It is the only master of the engine's control port.

Parameters:
- KEY, 32'h0F0F0F0F, data value sent with both Lock and Unlock.
- LOCKOUT_TIMER, 32'h0000000F, value sent with SetTimer.
- ROVER_TIMEOUT, 8, max cycles to wait for roundOver after C_start drops.

Ports:
- clk  in  1  single clock, all flops rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  round descriptor valid.
- cfg_ready  out  1  high only in IDLE.
- cfg_xval / cfg_yval / cfg_zval  in  32 each  X/Y/Z balances.
- cfg_mask  in  3  bidder enable mask.
- cfg_cost  in  32  bid charge.
- cfg_round_len  in  16  cycles C_start is held high.
- C_op  out  4  engine opcode (0 NoOp, 1 Unlock, 2 Lock, 3 LoadX, 4 LoadY, 5 LoadZ, 6 SetXYZmask, 7 SetTimer, 8 BidCharge).
- C_data  out  32  engine operand.
- C_start  out  1  round active.
- ready  in  1  engine ready.
- err  in  3  engine error code.
- roundOver  in  1  engine result strobe.
- maxBid  in  32  engine winning amount.
- X_win / Y_win / Z_win  in  1 each  engine winner flags.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed.
- res_maxbid  out  32  captured maxBid.
- res_winner  out  2  0 none, 1 X, 2 Y, 3 Z.
- res_err  out  3  0 ok, else captured engine err or 3'b111 timeout.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - C_op=0, C_data=0, C_start=0.
  - res_valid=0, res_maxbid=0, res_winner=0, res_err=0.
  - busy=0, cfg_ready=0 while reset is asserted and 1 after release.
  - Descriptor registers are cleared.
  - Reset mid-operation abandons the round immediately; no Unlock is issued.
- Output timing: C_op, C_data and C_start are registered and are a function of the current state only. In any state not listed as driving the bus, C_op=NoOp, C_data=0 and C_start=0.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid&cfg_ready, latch all cfg_* fields and go to LDX.
  - cfg_* is ignored in every other state.
- Config states, in order:
  - LDX: op 3, data xval.
  - LDY: op 4, data yval.
  - LDZ: op 5, data zval.
  - MSK: op 6, data {29'b0, mask}.
  - TMR: op 7, data LOCKOUT_TIMER.
  - CST: op 8, data cost.
  - LCK: op 2, data KEY.
- Config state rules:
  - A state advances only on a cycle where ready=1; while ready=0 it holds and re-presents the same op.
  - err is sampled on the advancing cycle of LDX..CST.
  - If err≠0: res_err=err, res_winner=0, res_maxbid=0, go to RESULT. No Lock is sent, so the engine stays unlocked.
  - err is not checked on LCK.
- RUN:
  - C_start=1, C_op=NoOp.
  - A 16-bit down-counter is loaded with max(round_len,1) on entry.
  - Exit to CLOSE on the cycle the counter reaches 1, so C_start is high for exactly max(round_len,1) consecutive cycles.
- CLOSE:
  - C_start=0.
  - Wait for roundOver=1. On that cycle capture maxBid into res_maxbid and err into res_err.
  - Winner capture: res_winner = X_win?1 : Y_win?2 : Z_win?3 : 0 (priority X>Y>Z).
  - Then go to UNLK.
  - If roundOver is not seen within ROVER_TIMEOUT cycles: res_err=3'b111, res_winner=0, res_maxbid=0, go to UNLK.
- UNLK: op 1, data KEY for exactly one cycle, independent of ready; then RESULT.
- RESULT:
  - res_valid=1 with res_* stable until the cycle res_valid&res_ready, then IDLE.
  - If res_ready is already high on entry, RESULT lasts one cycle.

Test Plan:
- Nominal round: X=100, Y=200, Z=300, mask=7, cost=1, len=4; engine responds with maxBid=300 and Z_win -> ops 3,4,5,6,7,8,2 on 7 consecutive cycles, C_start high exactly 4 cycles, one Unlock with data 0F0F0F0F, res_maxbid=300, res_winner=3, res_err=0.
- Backpressure: ready low for 3 cycles during LDY -> op 4 held 4 cycles with data=yval; later ops are unaffected. Hold res_ready low for 5 cycles -> res_valid and res_* are stable throughout.
- Config error: engine returns err=3'b100 on SetXYZmask -> no Lock or C_start is issued, res_err=100, res_winner=0, busy drops after the result handshake.
- Duplicate/timeout cases:
  - Engine returns err=3'b101 with roundOver and no winner -> res_err=101, res_winner=0.
  - Engine never asserts roundOver -> after 8 cycles res_err=111, Unlock is still issued.
- Edge cases:
  - round_len=0 -> C_start high exactly 1 cycle.
  - cfg_valid pulsed during RUN -> ignored, cfg_ready=0.
  - reset_n low mid-RUN -> C_start and C_op go to 0 with no clock edge, state=IDLE after release.
